// File: rtl/hbus_pkg.sv
// Shared types and constants for the hbus interconnect.
// Optional timeout support in the top is enabled with the HBUS_TIMEOUT_EN macro.
package hbus_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DFLT, TOUT} hbus_state_t;

    localparam logic [1:0] HSIZE_BYTE = 2'd0;
    localparam logic [1:0] HSIZE_HALF = 2'd1;
    localparam logic [1:0] HSIZE_WORD = 2'd2;

    // Slave index width covers 16 slaves plus the built-in error slave.
    localparam int unsigned SEL_W = 5;
    localparam logic [SEL_W-1:0] DEFAULT_SEL = 5'd16;

endpackage

// File: rtl/hbus_region_match.sv
// Combinational address decoder: base/mask comparators with lowest-index priority.
// Produces a one-hot select, the winning index, a hit flag and the slave-local offset.
module hbus_region_match
    import hbus_pkg::*;
#(
    parameter int unsigned             NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0
) (
    input  logic [31:0]           address,
    output logic [NUM_SLAVES-1:0] onehot,
    output logic [SEL_W-1:0]      index,
    output logic                  hit,
    output logic [31:0]           offset
);

    always_comb begin
        onehot = '0;
        index  = DEFAULT_SEL;
        hit    = 1'b0;
        offset = address;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && ((address & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32])) begin
                hit       = 1'b1;
                index     = SEL_W'(i);
                onehot[i] = 1'b1;
                offset    = address - SLAVE_BASE[32*i +: 32];
            end
        end
    end

endmodule

// File: rtl/hbus_interconnect.sv
// Single-master pipelined bus interconnect with a built-in error slave for unmapped addresses.
// Define HBUS_TIMEOUT_EN to abandon slaves that stall for TIMEOUT_CYCLES data-phase cycles.
module hbus_interconnect
    import hbus_pkg::*;
#(
    parameter int unsigned              NUM_SLAVES     = 4,
    parameter int unsigned              DATA_W         = 32,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {32'h1E000000, 32'h00000000, 32'h1FD003F8, 32'h1FC00000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {32'hFF000000, 32'hFFC00000, 32'hFFFFFFF8, 32'hFFFFFE00},
    parameter int unsigned              TIMEOUT_CYCLES = 256
) (
    input  logic                         Hclock,
    input  logic                         Hreset,
    input  logic                         Hvalid,
    input  logic [1:0]                   Hsize,
    input  logic                         Hwrite,
    input  logic [31:0]                  Haddress,
    input  logic [DATA_W-1:0]            Hwritedata,
    output logic [DATA_W-1:0]            Hreaddata,
    output logic                         Hready,
    output logic                         Hresponse,
    output logic [NUM_SLAVES-1:0]        Hselect_s,
    output logic [1:0]                   Hsize_s,
    output logic                         Hwrite_s,
    output logic [31:0]                  Haddress_s,
    output logic [DATA_W-1:0]            Hwritedata_s,
    input  logic [NUM_SLAVES*DATA_W-1:0] Hreaddata_s,
    input  logic [NUM_SLAVES-1:0]        Hready_s,
    input  logic [NUM_SLAVES-1:0]        Hresponse_s,
    output logic [7:0]                   Herr_count
);

    hbus_state_t             state;
    logic [SEL_W-1:0]        dsel;
    logic [NUM_SLAVES-1:0]   onehot;
    logic [SEL_W-1:0]        index;
    logic                    hit;
    logic                    accept;
    logic                    done;
    logic                    slave_ready;
    logic                    slave_resp;
    logic [DATA_W-1:0]       slave_rdata;

    hbus_region_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_match (
        .address (Haddress),
        .onehot  (onehot),
        .index   (index),
        .hit     (hit),
        .offset  (Haddress_s)
    );

    assign accept       = Hvalid && Hready;
    assign done         = (state != IDLE) && Hready;
    assign Hselect_s    = accept ? onehot : '0;
    assign Hsize_s      = Hsize;
    assign Hwrite_s     = Hwrite;
    assign Hwritedata_s = Hwritedata;

    always_comb begin
        slave_ready = 1'b0;
        slave_resp  = 1'b0;
        slave_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (dsel == SEL_W'(i)) begin
                slave_ready = Hready_s[i];
                slave_resp  = Hresponse_s[i];
                slave_rdata = Hreaddata_s[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        Hready    = 1'b1;
        Hresponse = 1'b0;
        Hreaddata = '0;
        case (state)
            BUSY: begin
                Hready    = slave_ready;
                Hresponse = slave_resp;
                Hreaddata = slave_rdata;
            end
            DFLT, TOUT: Hresponse = 1'b1;
            default: ;
        endcase
    end

`ifdef HBUS_TIMEOUT_EN
    localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tcount;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // An accept always coincides with completion of any current transfer, giving zero-bubble chaining.
    always_ff @(posedge Hclock or posedge Hreset) begin
        if (Hreset) begin
            state      <= IDLE;
            dsel       <= '0;
            Herr_count <= '0;
`ifdef HBUS_TIMEOUT_EN
            tcount     <= '0;
`endif
        end else begin
            if (done && Hresponse && (Herr_count != 8'hFF))
                Herr_count <= Herr_count + 8'd1;
            if (accept) begin
                state <= hit ? BUSY : DFLT;
                dsel  <= index;
`ifdef HBUS_TIMEOUT_EN
                tcount <= '0;
`endif
            end else if (done) begin
                state <= IDLE;
            end
`ifdef HBUS_TIMEOUT_EN
            else if (state == BUSY) begin
                tcount <= tcount + 16'd1;
                if (tcount + 16'd1 == TOUT_LAST)
                    state <= TOUT;
            end
`endif
        end
    end

endmodule

// File: tb/tb_hbus_interconnect.sv
// Scoreboard bench for hbus_interconnect with behavioural stalling slaves.
// The timeout scenario runs only when HBUS_TIMEOUT_EN is defined.
module tb_hbus_interconnect;
    import hbus_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        resp;
    } exp_t;

    logic         Hclock = 1'b0;
    logic         Hreset;
    logic         Hvalid;
    logic [1:0]   Hsize;
    logic         Hwrite;
    logic [31:0]  Haddress;
    logic [31:0]  Hwritedata;
    logic [31:0]  Hreaddata;
    logic         Hready;
    logic         Hresponse;
    logic [3:0]   Hselect_s;
    logic [1:0]   Hsize_s;
    logic         Hwrite_s;
    logic [31:0]  Haddress_s;
    logic [31:0]  Hwritedata_s;
    logic [127:0] Hreaddata_s;
    logic [3:0]   Hready_s;
    logic [3:0]   Hresponse_s;
    logic [7:0]   Herr_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_done = 0;
    logic        pending = 1'b0;
    exp_t        exp_q[$];
    exp_t        exp_e;

    int          stall[4];
    logic [31:0] rd[4];
    logic [3:0]  er;
    logic [3:0]  busy;
    int          scnt[4];

    hbus_interconnect #(
        .NUM_SLAVES     (4),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .Hclock       (Hclock),
        .Hreset       (Hreset),
        .Hvalid       (Hvalid),
        .Hsize        (Hsize),
        .Hwrite       (Hwrite),
        .Haddress     (Haddress),
        .Hwritedata   (Hwritedata),
        .Hreaddata    (Hreaddata),
        .Hready       (Hready),
        .Hresponse    (Hresponse),
        .Hselect_s    (Hselect_s),
        .Hsize_s      (Hsize_s),
        .Hwrite_s     (Hwrite_s),
        .Haddress_s   (Haddress_s),
        .Hwritedata_s (Hwritedata_s),
        .Hreaddata_s  (Hreaddata_s),
        .Hready_s     (Hready_s),
        .Hresponse_s  (Hresponse_s),
        .Herr_count   (Herr_count)
    );

    always #5 Hclock = ~Hclock;

    always @(posedge Hclock) cyc <= cyc + 1;

    // Slave i becomes ready stall[i] cycles after its select.
    always @(posedge Hclock or posedge Hreset) begin
        if (Hreset) begin
            for (int i = 0; i < 4; i++) begin
                busy[i] <= 1'b0;
                scnt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (Hselect_s[i]) begin
                    busy[i] <= 1'b1;
                    scnt[i] <= stall[i];
                end else if (busy[i]) begin
                    if (scnt[i] == 0) busy[i] <= 1'b0;
                    else scnt[i] <= scnt[i] - 1;
                end
            end
        end
    end

    always_comb begin
        Hready_s    = '0;
        Hresponse_s = '0;
        Hreaddata_s = '0;
        for (int i = 0; i < 4; i++) begin
            Hready_s[i]              = !busy[i] || (scnt[i] == 0);
            Hresponse_s[i]           = er[i];
            Hreaddata_s[32*i +: 32]  = rd[i];
        end
    end

    always @(negedge Hclock) begin
        if (Hreset) begin
            pending = 1'b0;
        end else begin
            if (pending && Hready) begin
                last_done = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL completion: got data %h resp %b, required no completion", Hreaddata, Hresponse);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (Hreaddata !== exp_e.rdata || Hresponse !== exp_e.resp) begin
                        errors++;
                        $display("FAIL completion: got data %h resp %b, required data %h resp %b",
                                 Hreaddata, Hresponse, exp_e.rdata, exp_e.resp);
                    end
                end
            end
            pending = (pending && !Hready) || (Hvalid && Hready);
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] esel, input logic [31:0] eoff,
                         input logic [31:0] erd, input logic eresp, output int acc);
        int n;
        Hvalid     = 1'b1;
        Hwrite     = w;
        Haddress   = a;
        Hwritedata = wd;
        Hsize      = HSIZE_WORD;
        n = 0;
        @(negedge Hclock);
        while (!Hready && n < 64) begin
            @(negedge Hclock);
            n++;
        end
        acc = cyc;
        checks++;
        if (!Hready) begin
            errors++;
            $display("FAIL accept %h: Hready stayed 0, required 1", a);
        end else begin
            checks++;
            if (Hselect_s !== esel) begin
                errors++;
                $display("FAIL select %h: got %b, required %b", a, Hselect_s, esel);
            end
            if (esel != 4'b0000) begin
                checks++;
                if (Haddress_s !== eoff) begin
                    errors++;
                    $display("FAIL offset %h: got %h, required %h", a, Haddress_s, eoff);
                end
            end
            checks++;
            if (Hwrite_s !== w || Hwritedata_s !== wd || Hsize_s !== HSIZE_WORD) begin
                errors++;
                $display("FAIL broadcast %h: got w %b wd %h size %0d, required w %b wd %h size %0d",
                         a, Hwrite_s, Hwritedata_s, Hsize_s, w, wd, HSIZE_WORD);
            end
            exp_q.push_back({erd, eresp});
        end
        @(posedge Hclock);
        #1;
    endtask

    task automatic drain();
        int n;
        Hvalid = 1'b0;
        n = 0;
        while ((pending || exp_q.size() != 0) && n < 64) begin
            @(negedge Hclock);
            n++;
        end
        checks++;
        if (pending || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d transfers outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge Hclock);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            stall[i] = 0;
            rd[i]    = '0;
        end
        er         = '0;
        Hreset     = 1'b1;
        Hvalid     = 1'b0;
        Hwrite     = 1'b0;
        Hsize      = HSIZE_WORD;
        Haddress   = 32'h1FC00000;
        Hwritedata = '0;
        repeat (3) @(posedge Hclock);
        #1;
        checks++;
        if (Hready !== 1'b1 || Hresponse !== 1'b0 || Hreaddata !== 32'h0 ||
            Hselect_s !== 4'b0000 || Herr_count !== 8'h00) begin
            errors++;
            $display("FAIL reset: got rdy %b resp %b data %h sel %b err %h, required 1 0 0 0000 00",
                     Hready, Hresponse, Hreaddata, Hselect_s, Herr_count);
        end
        Hreset = 1'b0;
        @(negedge Hclock);
        checks++;
        if (Hselect_s !== 4'b0000 || Hready !== 1'b1) begin
            errors++;
            $display("FAIL idle_cycle: got sel %b rdy %b, required 0000 1", Hselect_s, Hready);
        end
        @(posedge Hclock);
        #1;
    endtask

    task automatic test_read_rom();
        int a;
        stall[0] = 0;
        rd[0]    = 32'hDEADBEEF;
        er[0]    = 1'b0;
        issue(32'h1FC00004, 1'b0, 32'h0, 4'b0001, 32'h4, 32'hDEADBEEF, 1'b0, a);
        drain();
        checks++;
        if (last_done - a !== 1) begin
            errors++;
            $display("FAIL rom_latency: got %0d, required 1", last_done - a);
        end
    endtask

    task automatic test_stall();
        int a;
        stall[1] = 3;
        rd[1]    = 32'h000000A5;
        er[1]    = 1'b0;
        issue(32'h1FD003FD, 1'b0, 32'h0, 4'b0010, 32'h5, 32'h000000A5, 1'b0, a);
        drain();
        checks++;
        if (last_done - a !== 4) begin
            errors++;
            $display("FAIL stall_latency: got %0d, required 4", last_done - a);
        end
    endtask

    task automatic test_default();
        int a;
        issue(32'h80000000, 1'b1, 32'h12345678, 4'b0000, 32'h0, 32'h0, 1'b1, a);
        drain();
        checks++;
        if (last_done - a !== 1) begin
            errors++;
            $display("FAIL default_latency: got %0d, required 1", last_done - a);
        end
        checks++;
        if (Herr_count !== 8'd1) begin
            errors++;
            $display("FAIL err_count_default: got %0d, required 1", Herr_count);
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2;
        stall[2] = 0;
        rd[2]    = 32'h5A5A0000;
        er[2]    = 1'b0;
        stall[3] = 0;
        rd[3]    = 32'hF1A50000;
        er[3]    = 1'b1;
        issue(32'h00000100, 1'b0, 32'h0, 4'b0100, 32'h100, 32'h5A5A0000, 1'b0, a1);
        issue(32'h1E000010, 1'b0, 32'h0, 4'b1000, 32'h10, 32'hF1A50000, 1'b1, a2);
        drain();
        checks++;
        if (a2 - a1 !== 1) begin
            errors++;
            $display("FAIL back_to_back_gap: got %0d, required 1", a2 - a1);
        end
        checks++;
        if (Herr_count !== 8'd2) begin
            errors++;
            $display("FAIL err_count_slave: got %0d, required 2", Herr_count);
        end
        er[3] = 1'b0;
    endtask

`ifdef HBUS_TIMEOUT_EN
    task automatic test_timeout();
        int a;
        stall[2] = 100000;
        rd[2]    = 32'hBAD0BAD0;
        issue(32'h00000200, 1'b0, 32'h0, 4'b0100, 32'h200, 32'h0, 1'b1, a);
        drain();
        checks++;
        if (last_done - a !== 8) begin
            errors++;
            $display("FAIL timeout_cycle: got %0d, required 8", last_done - a);
        end
        checks++;
        if (Hready !== 1'b1 || Hresponse !== 1'b0 || Herr_count !== 8'd3) begin
            errors++;
            $display("FAIL timeout_idle: got rdy %b resp %b err %0d, required 1 0 3", Hready, Hresponse, Herr_count);
        end
    endtask
`endif

    task automatic test_mid_reset();
        int a;
        stall[2] = 5;
        rd[2]    = 32'h11112222;
        er[2]    = 1'b0;
        issue(32'h00000040, 1'b0, 32'h0, 4'b0100, 32'h40, 32'h11112222, 1'b0, a);
        Hvalid = 1'b0;
        @(posedge Hclock);
        #3;
        Hreset = 1'b1;
        #1;
        checks++;
        if (Hready !== 1'b1 || Hresponse !== 1'b0 || Hreaddata !== 32'h0 ||
            Hselect_s !== 4'b0000 || Herr_count !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got rdy %b resp %b data %h sel %b err %h, required 1 0 0 0000 00",
                     Hready, Hresponse, Hreaddata, Hselect_s, Herr_count);
        end
        exp_q.delete();
        @(posedge Hclock);
        #3;
        Hreset   = 1'b0;
        stall[2] = 0;
        rd[2]    = 32'h33334444;
        issue(32'h00000044, 1'b0, 32'h0, 4'b0100, 32'h44, 32'h33334444, 1'b0, a);
        drain();
        checks++;
        if (Herr_count !== 8'd0) begin
            errors++;
            $display("FAIL err_after_reset: got %0d, required 0", Herr_count);
        end
    endtask

    initial begin
        test_reset();
        test_read_rom();
        test_stall();
        test_default();
        test_back_to_back();
`ifdef HBUS_TIMEOUT_EN
        test_timeout();
`endif
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
